// File: rtl/crc_engine_p.sv
// crc_engine_p: bus-mapped CRC-16/CRC-32 engine with programmable polynomial, seed and transposition.
// Defining CRC_IN_FIFO_EN adds an input FIFO of FIFO_DEPTH DATA writes in front of the folding engine.
module crc_engine_p #(
    parameter logic [31:0] BASE_ADDR      = 32'h4003_2000,
    parameter int          BITS_PER_CYCLE = 1,
    parameter int          FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        RW,
    input  logic        Sel,
    input  logic [1:0]  size,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        ready,
    output logic        busy
);
    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      ctrl;
    logic [31:0]      gpoly;
    logic [31:0]      state;
    logic [31:0]      operand;
    logic [5:0]       count;
    logic [OCC_W-1:0] fifo_count;

    logic        hit_data, hit_gpoly, hit_ctrl, hit_status;
    logic [1:0]  tot, totr;
    logic        fxor, was, tcrc;
    logic [31:0] mask;
    logic        stall, acc_wr;
    logic        wr_seed, wr_fold, wr_gpoly, wr_ctrl;
    logic [31:0] lane;
    logic [31:0] seed_val;
    logic        load_en;
    logic [31:0] load_lane;
    logic [1:0]  load_size;
    logic [5:0]  load_cnt;
    logic [31:0] load_op;
    logic [31:0] fold_state, fold_op;
    logic [5:0]  fold_count;
    logic        fold_fb;
    logic [31:0] result;
    logic [31:0] status_rd;

    // N-bit transposition; v must be zero above bit n-1, the result is right-aligned.
    function automatic logic [31:0] transpose(input logic [31:0] v, input logic [1:0] mode,
                                              input logic [5:0] n);
        logic [31:0] r;
        r = v;
        case (mode)
            2'b01: begin
                for (int i = 0; i < 8; i++) begin
                    r[i]      = v[7 - i];
                    r[8 + i]  = v[15 - i];
                    r[16 + i] = v[23 - i];
                    r[24 + i] = v[31 - i];
                end
            end
            2'b10: begin
                for (int i = 0; i < 32; i++) r[i] = v[31 - i];
                r = r >> (6'd32 - n);
            end
            2'b11: begin
                r = {v[7:0], v[15:8], v[23:16], v[31:24]};
                r = r >> (6'd32 - n);
            end
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] size_bits(input logic [1:0] sz);
        case (sz)
            2'b00:   return 6'd8;
            2'b01:   return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    function automatic logic [31:0] lane_of(input logic [31:0] d, input logic [1:0] sz);
        case (sz)
            2'b00:   return {24'h0, d[7:0]};
            2'b01:   return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    assign hit_data   = (addr == BASE_ADDR);
    assign hit_gpoly  = (addr == BASE_ADDR + 32'h4);
    assign hit_ctrl   = (addr == BASE_ADDR + 32'h8);
    assign hit_status = (addr == BASE_ADDR + 32'hC);

    assign tot  = ctrl[31:30];
    assign totr = ctrl[29:28];
    assign fxor = ctrl[26];
    assign was  = ctrl[25];
    assign tcrc = ctrl[24];
    assign mask = tcrc ? 32'hFFFF_FFFF : 32'h0000_FFFF;

    assign ready    = !stall;
    assign acc_wr   = Sel && RW && ready;
    assign wr_seed  = acc_wr && hit_data && was;
    assign wr_fold  = acc_wr && hit_data && !was;
    assign wr_gpoly = acc_wr && hit_gpoly;
    assign wr_ctrl  = acc_wr && hit_ctrl;

    assign lane     = lane_of(data_wr, size);
    assign seed_val = transpose(lane, tot, size_bits(size)) & mask;
    assign load_cnt = size_bits(load_size);
    // Operand is left-aligned so the fold always consumes operand[31] first.
    assign load_op  = transpose(load_lane, tot, load_cnt) << (6'd32 - load_cnt);

    // A stored state left over from the other width is re-masked here before use.
    always_comb begin
        fold_state = state & mask;
        fold_op    = operand;
        fold_count = count;
        fold_fb    = 1'b0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (fold_count != '0) begin
                fold_fb    = (tcrc ? fold_state[31] : fold_state[15]) ^ fold_op[31];
                fold_state = (fold_state << 1) & mask;
                if (fold_fb) fold_state = fold_state ^ (gpoly & mask);
                fold_op    = fold_op << 1;
                fold_count = fold_count - 6'd1;
            end
        end
    end

`ifdef CRC_IN_FIFO_EN
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [31:0]      fifo_lane [FIFO_DEPTH];
    logic [1:0]       fifo_size [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full, finishing, can_load, push, pop, engine_active;

    assign fifo_empty    = (fifo_count == '0);
    assign fifo_full     = (fifo_count == OCC_W'(FIFO_DEPTH));
    assign finishing     = busy && (fold_count == '0);
    assign can_load      = !busy || finishing;
    assign pop           = can_load && !fifo_empty;
    assign engine_active = busy || !fifo_empty;
    // An idle engine with nothing queued takes the write directly, keeping the unbuffered latency.
    assign push          = wr_fold && !(can_load && fifo_empty);
    assign load_en       = pop || (wr_fold && can_load && fifo_empty);
    assign load_lane     = pop ? fifo_lane[rd_ptr] : lane;
    assign load_size     = pop ? fifo_size[rd_ptr] : size;

    assign stall = Sel && ((hit_data && RW && !was && fifo_full && !pop) ||
                           (hit_data && (!RW || was) && engine_active) ||
                           (RW && (hit_gpoly || hit_ctrl) && engine_active));

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_lane[wr_ptr] <= lane;
            fifo_size[wr_ptr] <= size;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + OCC_W'(1);
                2'b01:   fifo_count <= fifo_count - OCC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
`else
    assign fifo_count = '0;
    assign load_en    = wr_fold;
    assign load_lane  = lane;
    assign load_size  = size;
    assign stall      = Sel && busy && (hit_data || (RW && (hit_gpoly || hit_ctrl)));
`endif

    // Writes to state/GPOLY/CTRL are only accepted while idle, so they never race the fold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl    <= '0;
            gpoly   <= 32'h0000_1021;
            state   <= 32'h0000_FFFF;
            operand <= '0;
            count   <= '0;
            busy    <= 1'b0;
        end else begin
            if (busy) begin
                state   <= fold_state;
                operand <= fold_op;
                count   <= fold_count;
                busy    <= (fold_count != '0);
            end
            if (load_en) begin
                operand <= load_op;
                count   <= load_cnt;
                busy    <= 1'b1;
            end
            if (wr_seed)  state <= seed_val;
            if (wr_gpoly) gpoly <= data_wr;
            if (wr_ctrl)  ctrl  <= data_wr;
        end
    end

    always_comb begin
        result = transpose(state & mask, totr, tcrc ? 6'd32 : 6'd16);
        if (fxor) result = result ^ mask;
    end

    assign status_rd = {24'h0, 4'(fifo_count), 3'b000, busy};

    always_comb begin
        data_rd = '0;
        if (rst && Sel && !RW && ready) begin
            if (hit_data)        data_rd = result;
            else if (hit_gpoly)  data_rd = gpoly;
            else if (hit_ctrl)   data_rd = ctrl;
            else if (hit_status) data_rd = status_rd;
        end
    end
endmodule

// File: tb/tb_crc_engine_p.sv
// tb_crc_engine_p: directed self-checking bench for crc_engine_p using known CRC check vectors.
// Expected values depend on whether CRC_IN_FIFO_EN is defined.
module tb_crc_engine_p;
    localparam logic [31:0] BASE     = 32'h4003_2000;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_GPOLY  = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;
    localparam int          BPC      = 1;
`ifdef CRC_IN_FIFO_EN
    localparam bit HAS_FIFO = 1'b1;
`else
    localparam bit HAS_FIFO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        RW = 1'b0;
    logic        Sel = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] data_wr = '0;
    logic [31:0] data_rd;
    logic        ready;
    logic        busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    crc_engine_p #(.BASE_ADDR(BASE), .BITS_PER_CYCLE(BPC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .addr(addr), .RW(RW), .Sel(Sel), .size(size),
        .data_wr(data_wr), .data_rd(data_rd), .ready(ready), .busy(busy)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             output int stalls);
        stalls = 0;
        @(negedge clk);
        addr = a; RW = 1'b1; Sel = 1'b1; size = sz; data_wr = d;
        #1;
        while (!ready && stalls < 400) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!ready) begin
            checks++;
            $display("[TB] FAIL write_timeout: addr %h still stalled after %0d cycles, required ready", a, stalls);
        end
        @(posedge clk); #1;
        Sel = 1'b0; RW = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int s;
        bus_write(a, d, sz, s);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int stalls);
        stalls = 0;
        @(negedge clk);
        addr = a; RW = 1'b0; Sel = 1'b1;
        #1;
        while (!ready && stalls < 400) begin
            @(negedge clk); #1;
            stalls++;
        end
        if (!ready) begin
            checks++;
            $display("[TB] FAIL read_timeout: addr %h still stalled after %0d cycles, required ready", a, stalls);
        end
        d = data_rd;
        @(posedge clk); #1;
        Sel = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        int s;
        bus_read(a, d, s);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int n = 0;
        rd(A_STATUS, s);
        while ((s[0] || s[7:4] != 4'h0) && n < 500) begin
            rd(A_STATUS, s);
            n++;
        end
        if (s[0] || s[7:4] != 4'h0) begin
            checks++;
            $display("[TB] FAIL idle_timeout: STATUS %h after %0d polls, required busy=0 and empty", s, n);
        end
    endtask

    task automatic write_msg();
        for (int i = 0; i < 9; i++) wr(A_DATA, 32'hABCD_EF00 | (32'h31 + 32'(i)), 2'b00);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", ready); else passes++;
        checks++; if (data_rd !== 32'h0) $display("[TB] FAIL reset_rd_idle: got %h want 0", data_rd); else passes++;
        addr = A_GPOLY; RW = 1'b0; Sel = 1'b1;
        #1;
        checks++; if (data_rd !== 32'h0) $display("[TB] FAIL reset_rd_sel: got %h want 0", data_rd); else passes++;
        Sel = 1'b0;
        @(negedge clk) rst = 1'b1;
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL reset_ctrl: got %h want 0", v); else passes++;
        rd(A_GPOLY, v);
        checks++; if (v !== 32'h0000_1021) $display("[TB] FAIL reset_gpoly: got %h want 00001021", v); else passes++;
        rd(A_DATA, v);
        checks++; if (v !== 32'h0000_FFFF) $display("[TB] FAIL reset_state: got %h want 0000ffff", v); else passes++;
        rd(A_STATUS, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL reset_status: got %h want 0", v); else passes++;
    endtask

    task automatic test_ccitt();
        logic [31:0] v;
        wr(A_CTRL, 32'h0, 2'b10);
        write_msg();
        wait_idle();
        rd(A_DATA, v);
        checks++; if (v !== 32'h0000_29B1) $display("[TB] FAIL ccitt_bytes: got %h want 000029b1", v); else passes++;
    endtask

    task automatic test_sizes();
        logic [31:0] v;
        wr(A_CTRL, 32'h0200_0000, 2'b10);
        wr(A_DATA, 32'h1234_FFFF, 2'b10);
        wr(A_CTRL, 32'h0, 2'b10);
        wr(A_DATA, 32'hDEAD_3132, 2'b01);
        wr(A_DATA, 32'hDEAD_3334, 2'b01);
        wr(A_DATA, 32'hDEAD_3536, 2'b01);
        wr(A_DATA, 32'hDEAD_3738, 2'b01);
        wr(A_DATA, 32'hDEAD_BE39, 2'b00);
        wait_idle();
        rd(A_DATA, v);
        checks++; if (v !== 32'h0000_29B1) $display("[TB] FAIL ccitt_halfwords: got %h want 000029b1", v); else passes++;
        wr(A_CTRL, 32'h0200_0000, 2'b10);
        wr(A_DATA, 32'h0000_FFFF, 2'b10);
        wr(A_CTRL, 32'hC000_0000, 2'b10);
        wr(A_DATA, 32'h3433_3231, 2'b10);
        wr(A_DATA, 32'h3837_3635, 2'b10);
        wr(A_DATA, 32'h0000_0039, 2'b00);
        wait_idle();
        rd(A_DATA, v);
        checks++; if (v !== 32'h0000_29B1) $display("[TB] FAIL ccitt_tot_byteswap: got %h want 000029b1", v); else passes++;
        wr(A_CTRL, 32'h0400_0000, 2'b10);
        rd(A_DATA, v);
        checks++; if (v !== 32'h0000_D64E) $display("[TB] FAIL ccitt_fxor16: got %h want 0000d64e", v); else passes++;
    endtask

    task automatic test_mpeg2();
        logic [31:0] v;
        wr(A_CTRL, 32'h0300_0000, 2'b10);
        wr(A_DATA, 32'hFFFF_FFFF, 2'b10);
        checks++; if (busy !== 1'b0) $display("[TB] FAIL seed_busy: got %b want 0", busy); else passes++;
        wr(A_GPOLY, 32'h04C1_1DB7, 2'b10);
        wr(A_CTRL, 32'h0100_0000, 2'b10);
        write_msg();
        wait_idle();
        rd(A_DATA, v);
        checks++; if (v !== 32'h0376_E6E7) $display("[TB] FAIL mpeg2_crc: got %h want 0376e6e7", v); else passes++;
        rd(A_GPOLY, v);
        checks++; if (v !== 32'h04C1_1DB7) $display("[TB] FAIL gpoly_readback: got %h want 04c11db7", v); else passes++;
    endtask

    task automatic test_crc32();
        logic [31:0] v;
        wr(A_CTRL, 32'h0300_0000, 2'b10);
        wr(A_DATA, 32'hFFFF_FFFF, 2'b10);
        wr(A_CTRL, 32'h6500_0000, 2'b10);
        write_msg();
        rd(A_DATA, v);
        checks++; if (v !== 32'hCBF4_3926) $display("[TB] FAIL crc32_std: got %h want cbf43926", v); else passes++;
    endtask

    task automatic test_latency();
        int n;
        int s;
        wr(A_CTRL, 32'h0100_0000, 2'b10);
        wr(A_DATA, 32'h1234_5678, 2'b10);
        n = 0;
        while (busy && n < 100) begin n++; @(posedge clk); #1; end
        checks++; if (n != 32 / BPC) $display("[TB] FAIL latency_word: busy %0d cycles want %0d", n, 32 / BPC); else passes++;
        wr(A_DATA, 32'h0000_00A5, 2'b00);
        n = 0;
        while (busy && n < 100) begin n++; @(posedge clk); #1; end
        checks++; if (n != 8 / BPC) $display("[TB] FAIL latency_byte: busy %0d cycles want %0d", n, 8 / BPC); else passes++;
        wr(A_DATA, 32'h1111_2222, 2'b10);
        bus_write(A_DATA, 32'h3333_4444, 2'b10, s);
        checks++;
        if (s != (HAS_FIFO ? 0 : 32 / BPC))
            $display("[TB] FAIL busy_stall: stalled %0d cycles want %0d", s, HAS_FIFO ? 0 : 32 / BPC);
        else passes++;
        wait_idle();
    endtask

    task automatic test_unmapped();
        logic [31:0] v;
        int s;
        wr(A_CTRL, 32'h0300_0000, 2'b10);
        wr(A_DATA, 32'hA5A5_5A5A, 2'b10);
        wr(A_CTRL, 32'h0100_0000, 2'b10);
        bus_write(BASE + 32'h10, 32'hFFFF_FFFF, 2'b10, s);
        checks++; if (s != 0) $display("[TB] FAIL unmapped_wr_ready: stalled %0d want 0", s); else passes++;
        wr(BASE + 32'h2, 32'hFFFF_FFFF, 2'b10);
        wr(BASE + 32'h9, 32'hFFFF_FFFF, 2'b10);
        wr(A_STATUS, 32'hFFFF_FFFF, 2'b10);
        rd(BASE + 32'h10, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL unmapped_rd_out: got %h want 0", v); else passes++;
        rd(BASE + 32'h1, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL unmapped_rd_in: got %h want 0", v); else passes++;
        rd(A_DATA, v);
        checks++; if (v !== 32'hA5A5_5A5A) $display("[TB] FAIL unmapped_state: got %h want a5a55a5a", v); else passes++;
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0100_0000) $display("[TB] FAIL unmapped_ctrl: got %h want 01000000", v); else passes++;
        rd(A_STATUS, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL status_ro: got %h want 0", v); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [6];
        logic [31:0] v;
        int idx = 0;
        int first_stall = -1;
        int guard = 0;
        words[0] = 32'h1111_1111; words[1] = 32'h2222_2222; words[2] = 32'h4444_4444;
        words[3] = 32'h8888_8888; words[4] = 32'h0123_4567; words[5] = 32'h89AB_CDEF;
        wr(A_CTRL, 32'h0300_0000, 2'b10);
        wr(A_DATA, 32'h0, 2'b10);
        wr(A_GPOLY, 32'h0000_0001, 2'b10);
        wr(A_CTRL, 32'h0100_0000, 2'b10);
        @(negedge clk);
        while (idx < 6 && guard < 600) begin
            addr = A_DATA; RW = 1'b1; Sel = 1'b1; size = 2'b10; data_wr = words[idx];
            #1;
            if (ready) idx++;
            else if (first_stall < 0) first_stall = idx;
            @(negedge clk);
            guard++;
        end
        Sel = 1'b0; RW = 1'b0;
        checks++;
        if (first_stall != (HAS_FIFO ? 5 : 1))
            $display("[TB] FAIL first_stall_index: got %0d want %0d", first_stall, HAS_FIFO ? 5 : 1);
        else passes++;
        wait_idle();
        rd(A_DATA, v);
        checks++; if (v !== 32'h7777_7777) $display("[TB] FAIL back_to_back_result: got %h want 77777777", v); else passes++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        wr(A_GPOLY, 32'h04C1_1DB7, 2'b10);
        wr(A_CTRL, 32'h0100_0000, 2'b10);
        wr(A_DATA, 32'hDEAD_BEEF, 2'b10);
        if (HAS_FIFO) wr(A_DATA, 32'hCAFE_F00D, 2'b10);
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b want 0", busy); else passes++;
        checks++; if (ready !== 1'b1) $display("[TB] FAIL midreset_ready: got %b want 1", ready); else passes++;
        @(negedge clk) rst = 1'b1;
        rd(A_CTRL, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL midreset_ctrl: got %h want 0", v); else passes++;
        rd(A_GPOLY, v);
        checks++; if (v !== 32'h0000_1021) $display("[TB] FAIL midreset_gpoly: got %h want 00001021", v); else passes++;
        rd(A_DATA, v);
        checks++; if (v !== 32'h0000_FFFF) $display("[TB] FAIL midreset_state: got %h want 0000ffff", v); else passes++;
        rd(A_STATUS, v);
        checks++; if (v !== 32'h0) $display("[TB] FAIL midreset_status: got %h want 0", v); else passes++;
    endtask

    initial begin
        test_reset();
        test_ccitt();
        test_sizes();
        test_mpeg2();
        test_crc32();
        test_latency();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit with %0d/%0d checks", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/crc_engine_p.md
Name: crc_engine_p

Overview:
- Parametrised, bus-mapped CRC engine; next generation of the CRC peripheral block.
- Computes CRC-16 or CRC-32 using a programmable polynomial, seed and bit/byte transposition. Also supports byte, halfword and word data writes.
- Processes data serially at BITS_PER_CYCLE bits per clock, using a busy/ready handshake toward the register bus.

Parameters:
BASE_ADDR, 32'h4003_2000, base of 16-byte register window: DATA +0x0, GPOLY +0x4, CTRL +0x8, STATUS +0xC
BITS_PER_CYCLE, 1, bits folded per clock; legal 1, 2, 4, 8
FIFO_DEPTH, 4, input FIFO entries (power of 2, >=2); used only with CRC_IN_FIFO_EN

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low
addr  in  32  byte address
RW  in  1  1 = write, 0 = read
Sel  in  1  access strobe; one access per cycle while high
size  in  2  write width: 00 byte (data_wr[7:0]), 01 halfword ([15:0]), 10/11 word
data_wr  in  32  write data
data_rd  out  32  read data, combinational, valid when Sel & !RW & ready
ready  out  1  access accepted this cycle; low = stall, master holds addr/RW/Sel/size/data_wr
busy  out  1  engine folding data

Behaviour:
- Reset (rst=0, async): CTRL=0, GPOLY=0x0000_1021, state=0x0000_FFFF, count=0, busy=0, ready=1, data_rd=0. Any in-flight computation is aborted.
- CTRL fields: [31:30] TOT, [29:28] TOTR, [26] FXOR, [25] WAS, [24] TCRC (1 = 32-bit, 0 = 16-bit). Other bits are read/write storage only. Effective width W = TCRC ? 32 : 16.
- Transpose on N-bit value (N = 8/16/32 for TOT, W for TOTR):
  - 00 none
  - 01 reverse bits within each byte
  - 10 reverse all N bits
  - 11 reverse byte order
- DATA write with WAS=1: state <= TOT(lane) masked to W, zero-extended. Completes in 1 cycle; busy stays 0.
- DATA write with WAS=0: operand <= TOT(lane); count <= 8·bytes; busy=1 from the next cycle.
- Per bit, MSB of operand first: fb = state[W-1] ^ d; state = (state << 1) masked to W; if fb, state ^= GPOLY[W-1:0].
- Each cycle folds min(BITS_PER_CYCLE, count) bits; count decrements by the same amount; busy=0 the cycle after count reaches 0.
- Latency: byte = 8/BITS_PER_CYCLE cycles, word = 32/BITS_PER_CYCLE cycles.
- DATA read: FXOR ? TOTR(state) ^ {W{1}} : TOTR(state). Upper 16 bits are 0 in 16-bit mode.
- Stall rules: ready=0 when busy and Sel is high with any of:
  - a DATA write
  - a DATA read
  - a GPOLY write
  - a CTRL write
- Never stalled: reads of CTRL, GPOLY and STATUS.
- STATUS (read-only): [0] busy, [7:4] FIFO occupancy (0 without FIFO). Writes to STATUS are ignored.
- Unmapped address inside or outside the window: ready=1, data_rd=0, no state change.
- A CTRL write takes effect on the next access. Changing TCRC does not alter state bits; the stored value is re-masked on next use.
- Sel low: data_rd=0, ready=1.

Optional Feature:
Macro CRC_IN_FIFO_EN.
- Defined:
  - DATA writes with WAS=0 push {lane, size} into a FIFO_DEPTH-entry FIFO. ready stays high while the FIFO is not full.
  - The engine pops the next entry in the cycle it finishes, giving back-to-back operation with no idle cycle.
  - Push and pop in the same cycle while full is accepted.
  - Full: ready=0 for a DATA write.
  - Seed writes, GPOLY/CTRL writes and DATA reads stall until the FIFO is empty and busy=0.
  - Reset flushes the FIFO.
- Undefined: no FIFO; stall rules above apply; STATUS[7:4]=0.

Test Plan:
- CCITT-16: reset, CTRL=0, write bytes "123456789" (size=00), poll STATUS, read DATA -> 0x0000_29B1.
- MPEG-2 CRC-32: CTRL=0x0300_0000, DATA=0xFFFF_FFFF (seed), GPOLY=0x04C1_1DB7, CTRL=0x0100_0000, nine byte writes -> DATA reads 0x0376_E6E7.
- Standard CRC-32 with TOT=01, TOTR=10, FXOR=1, TCRC=1, same seed, poly and bytes -> DATA reads 0xCBF4_3926.
- Latency, BITS_PER_CYCLE=1: one word write -> busy high exactly 32 cycles. A second DATA write during busy -> ready=0 until busy falls (no FIFO), or accepted immediately (FIFO).
- Reset mid-operation: assert rst during cycle 10 of a word fold -> busy=0, state=0x0000_FFFF, GPOLY=0x1021, CTRL=0 immediately. With FIFO, STATUS[7:4]=0.
- FIFO full, CRC_IN_FIFO_EN, FIFO_DEPTH=4, BITS_PER_CYCLE=1: six back-to-back word writes -> ready drops on the sixth. Result equals the same sequence written without stalls.
